edge_detect_multi: RTL and testbench

Multi-channel, parametrised edge detector with per-channel mode select, input synchronisation, pulse stretching and sticky pending flags. It is the generalised successor of the single-bit `clk`/`rstn`/`in`/`out` edge-detect exercise block. It is intended as a drop-in event front-end for wider exercise designs: GPIO interrupt sources and button or strobe capture. Every channel is independent; only the clock, the reset and the `any_out` reduction are shared.

---
 rtl/edge_detect_multi_if.sv | 21 ++
 rtl/edge_detect_multi.sv | 92 +++++++++
 tb/tb_edge_detect_multi.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_multi_if.sv
// Event front-end bundle: raw inputs, per-channel mode and clear in, pulses and sticky flags out.
interface edge_detect_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   out;
    logic [CH-1:0]   pending;
    logic            any_out;

    modport master (
        output in, mode, clr,
        input  out, pending, any_out
    );

    modport slave (
        input  in, mode, clr,
        output out, pending, any_out
    );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: input synchroniser, per-channel mode select,
// retriggerable pulse stretcher and write-1-to-clear sticky pending flags.
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    edge_detect_multi_if.slave   bus
);
    localparam int CW = $clog2(STRETCH + 1);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH);

    logic [CH-1:0] d;
    logic [CH-1:0] prev;
    logic [CH-1:0] event_hit;
    logic [CH-1:0] out_q;
    logic [CH-1:0] pending_q;
    logic [CW-1:0] cnt      [CH];
    logic [CW-1:0] cnt_next [CH];

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign d = bus.in;
        end else begin : g_sync
            logic [CH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rstn) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= bus.in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign d = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        event_hit = '0;
        for (int i = 0; i < CH; i++) begin
            case (bus.mode[2*i +: 2])
                2'b01:   event_hit[i] = d[i] & ~prev[i];
                2'b10:   event_hit[i] = ~d[i] & prev[i];
                2'b11:   event_hit[i] = d[i] ^ prev[i];
                default: event_hit[i] = 1'b0;
            endcase
        end
    end

    // An event always reloads, so a retrigger extends the pulse with no gap.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_next[i] = cnt[i];
            if (event_hit[i]) begin
                cnt_next[i] = LOAD;
            end else if (cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - CW'(1);
            end
        end
    end

    // prev follows d in every mode so a mode switch never sees stale history.
    always_ff @(posedge clk) begin
        if (rstn) begin
            prev      <= '0;
            out_q     <= '0;
            pending_q <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prev      <= d;
            pending_q <= event_hit | (pending_q & ~bus.clr);
            for (int i = 0; i < CH; i++) begin
                cnt[i]   <= cnt_next[i];
                out_q[i] <= (cnt_next[i] != '0);
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.pending = pending_q;
    assign bus.any_out = |out_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: three configurations share one stimulus and are
// compared every cycle against an event-age model, plus hand-computed spot values.
module tb_edge_detect_multi;
    localparam int CH = 4;

    logic            clk;
    logic            rst_v;
    logic [CH-1:0]   in_v;
    logic [2*CH-1:0] mode_v;
    logic [CH-1:0]   clr_v;

    int total = 0;
    int bad   = 0;

    edge_detect_multi_if #(.CH(CH)) ifa ();
    edge_detect_multi_if #(.CH(CH)) ifb ();
    edge_detect_multi_if #(.CH(CH)) ifc ();

    assign ifa.in = in_v;  assign ifa.mode = mode_v;  assign ifa.clr = clr_v;
    assign ifb.in = in_v;  assign ifb.mode = mode_v;  assign ifb.clr = clr_v;
    assign ifc.in = in_v;  assign ifc.mode = mode_v;  assign ifc.clr = clr_v;

    edge_detect_multi #(.CH(CH), .SYNC_STAGES(2), .STRETCH(1)) dut_a (
        .clk (clk), .rstn(rst_v), .bus (ifa)
    );
    edge_detect_multi #(.CH(CH), .SYNC_STAGES(0), .STRETCH(4)) dut_b (
        .clk (clk), .rstn(rst_v), .bus (ifb)
    );
    edge_detect_multi #(.CH(CH), .SYNC_STAGES(2), .STRETCH(8)) dut_c (
        .clk (clk), .rstn(rst_v), .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic int s_of(input int c);
        case (c)
            0:       return 2;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int st_of(input int c);
        case (c)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input time t, input logic rst, input logic [CH-1:0] inp,
                                 input logic [2*CH-1:0] md, input logic [CH-1:0] cl);
        #(t - $time);
        rst_v  = rst;
        in_v   = inp;
        mode_v = md;
        clr_v  = cl;
    endtask

    // Model: input samples by age, with reset flushing the in-flight history;
    // an output is high while the latest event is younger than STRETCH edges.
    logic [CH-1:0] hs     [3][8];
    int            age    [3][CH];
    bit            alive  [3][CH];
    logic [CH-1:0] m_out  [3];
    logic [CH-1:0] m_pend [3];

    initial begin
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 8; k++) hs[c][k] = '0;
            for (int i = 0; i < CH; i++) begin
                age[c][i]   = 1000;
                alive[c][i] = 1'b0;
            end
            m_out[c]  = '0;
            m_pend[c] = '0;
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            for (int k = 7; k > 0; k--) hs[c][k] = hs[c][k-1];
            hs[c][0] = in_v;
            if (rst_v) begin
                for (int k = 0; k <= s_of(c); k++) hs[c][k] = '0;
                m_out[c]  = '0;
                m_pend[c] = '0;
                for (int i = 0; i < CH; i++) alive[c][i] = 1'b0;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    logic now_v, old_v, ev;
                    now_v = hs[c][s_of(c)][i];
                    old_v = hs[c][s_of(c)+1][i];
                    case (mode_v[2*i +: 2])
                        2'b01:   ev = now_v && !old_v;
                        2'b10:   ev = !now_v && old_v;
                        2'b11:   ev = now_v != old_v;
                        default: ev = 1'b0;
                    endcase
                    if (ev) begin
                        age[c][i]   = 0;
                        alive[c][i] = 1'b1;
                    end else if (age[c][i] < 1000) begin
                        age[c][i]++;
                    end
                    m_out[c][i]  = alive[c][i] && (age[c][i] < st_of(c));
                    m_pend[c][i] = ev || (m_pend[c][i] && !clr_v[i]);
                end
            end
        end
        #1;
        checkOutput("A out",     {4'h0, ifa.out},     {4'h0, m_out[0]});
        checkOutput("A pending", {4'h0, ifa.pending}, {4'h0, m_pend[0]});
        checkOutput("A any_out", {7'h0, ifa.any_out}, {7'h0, |m_out[0]});
        checkOutput("B out",     {4'h0, ifb.out},     {4'h0, m_out[1]});
        checkOutput("B pending", {4'h0, ifb.pending}, {4'h0, m_pend[1]});
        checkOutput("B any_out", {7'h0, ifb.any_out}, {7'h0, |m_out[1]});
        checkOutput("C out",     {4'h0, ifc.out},     {4'h0, m_out[2]});
        checkOutput("C pending", {4'h0, ifc.pending}, {4'h0, m_pend[2]});
        checkOutput("C any_out", {7'h0, ifc.any_out}, {7'h0, |m_out[2]});
    end

    // Spot values below are worked out by hand from the edge times (edges at 10+20n ns).
    initial begin
        rst_v  = 1'b1;
        in_v   = '0;
        mode_v = 8'b00_00_11_01;
        clr_v  = '0;

        #31;
        checkOutput("reset A out",     {4'h0, ifa.out},     8'h00);
        checkOutput("reset A pending", {4'h0, ifa.pending}, 8'h00);
        checkOutput("reset A any_out", {7'h0, ifa.any_out}, 8'h00);

        applyStimulus(40,  1'b0, 4'b0000, 8'b00_00_11_01, 4'b0000);
        applyStimulus(115, 1'b0, 4'b0011, 8'b00_00_11_01, 4'b0000);
        #(131 - $time);
        checkOutput("rise A out0 early", {7'h0, ifa.out[0]}, 8'h00);
        applyStimulus(140, 1'b0, 4'b0001, 8'b00_00_11_01, 4'b0000);
        #(151 - $time);
        checkOutput("rise A out0 pre", {7'h0, ifa.out[0]}, 8'h00);
        applyStimulus(165, 1'b0, 4'b0011, 8'b00_00_11_01, 4'b0000);
        #(171 - $time);
        checkOutput("rise A out0",   {7'h0, ifa.out[0]},     8'h01);
        checkOutput("rise A pend0",  {7'h0, ifa.pending[0]}, 8'h01);
        checkOutput("both A out1 1", {7'h0, ifa.out[1]},     8'h01);
        applyStimulus(190, 1'b0, 4'b0001, 8'b00_00_11_01, 4'b0000);
        #(191 - $time);
        checkOutput("rise A out0 post", {7'h0, ifa.out[0]},  8'h00);
        checkOutput("both A out1 2",    {7'h0, ifa.out[1]},  8'h01);
        checkOutput("both A any_out",   {7'h0, ifa.any_out}, 8'h01);
        #(211 - $time);
        checkOutput("both A out1 3", {7'h0, ifa.out[1]}, 8'h01);
        #(231 - $time);
        checkOutput("both A out1 4", {7'h0, ifa.out[1]},     8'h01);
        checkOutput("rise A pend0 2", {7'h0, ifa.pending[0]}, 8'h01);
        #(251 - $time);
        checkOutput("both A out1 end", {7'h0, ifa.out[1]},     8'h00);
        checkOutput("both A pend1",    {7'h0, ifa.pending[1]}, 8'h01);
        checkOutput("both A any end",  {7'h0, ifa.any_out},    8'h00);

        applyStimulus(300, 1'b0, 4'b0001, 8'b00_01_11_01, 4'b0000);
        applyStimulus(360, 1'b0, 4'b0101, 8'b00_01_11_01, 4'b0000);
        #(361 - $time);
        checkOutput("stretch B pre", {7'h0, ifb.out[2]}, 8'h00);
        #(371 - $time);
        checkOutput("stretch B e10", {7'h0, ifb.out[2]}, 8'h01);
        applyStimulus(380, 1'b0, 4'b0001, 8'b00_01_11_01, 4'b0000);
        #(391 - $time);
        checkOutput("stretch B e11", {7'h0, ifb.out[2]}, 8'h01);
        applyStimulus(400, 1'b0, 4'b0101, 8'b00_01_11_01, 4'b0000);
        #(411 - $time);
        checkOutput("stretch B e12", {7'h0, ifb.out[2]}, 8'h01);
        #(471 - $time);
        checkOutput("stretch B e15", {7'h0, ifb.out[2]}, 8'h01);
        #(491 - $time);
        checkOutput("stretch B e16", {7'h0, ifb.out[2]}, 8'h00);

        applyStimulus(500, 1'b0, 4'b0000, 8'b00_01_11_01, 4'b0000);
        #(511 - $time);
        checkOutput("clr B pend0 held", {7'h0, ifb.pending[0]}, 8'h01);
        applyStimulus(520, 1'b0, 4'b0001, 8'b00_01_11_01, 4'b0001);
        #(531 - $time);
        checkOutput("clr B race set wins", {7'h0, ifb.pending[0]}, 8'h01);
        #(551 - $time);
        checkOutput("clr B cleared", {7'h0, ifb.pending[0]}, 8'h00);
        applyStimulus(560, 1'b0, 4'b0001, 8'b00_01_11_01, 4'b0000);

        applyStimulus(600, 1'b0, 4'b0000, 8'b11_10_01_00, 4'b1111);
        applyStimulus(640, 1'b0, 4'b0000, 8'b11_10_01_00, 4'b0000);
        applyStimulus(700, 1'b0, 4'b1111, 8'b11_10_01_00, 4'b0000);
        #(751 - $time);
        checkOutput("modes C rise out",  {4'h0, ifc.out},     8'h0a);
        checkOutput("modes C rise pend", {4'h0, ifc.pending}, 8'h0a);
        applyStimulus(800, 1'b0, 4'b0000, 8'b11_10_01_00, 4'b0000);
        #(851 - $time);
        checkOutput("modes C fall out",  {4'h0, ifc.out},     8'h0e);
        checkOutput("modes C fall pend", {4'h0, ifc.pending}, 8'h0e);
        applyStimulus(860, 1'b1, 4'b0000, 8'b11_10_01_00, 4'b0000);
        #(871 - $time);
        checkOutput("abort C out",     {4'h0, ifc.out},     8'h00);
        checkOutput("abort C pending", {4'h0, ifc.pending}, 8'h00);
        checkOutput("abort C any_out", {7'h0, ifc.any_out}, 8'h00);
        applyStimulus(880, 1'b0, 4'b0000, 8'b11_10_01_00, 4'b0000);
        #(951 - $time);
        checkOutput("abort C stays low", {4'h0, ifc.out}, 8'h00);

        applyStimulus(960,  1'b0, 4'b0010, 8'b11_10_01_00, 4'b0000);
        applyStimulus(980,  1'b1, 4'b0010, 8'b11_10_01_00, 4'b0000);
        applyStimulus(1020, 1'b0, 4'b0010, 8'b11_10_01_00, 4'b0000);
        #(1051 - $time);
        checkOutput("held A before", {4'h0, ifa.out}, 8'h00);
        #(1071 - $time);
        checkOutput("held A pulse",   {4'h0, ifa.out},     8'h02);
        checkOutput("held A pending", {4'h0, ifa.pending}, 8'h02);
        #(1091 - $time);
        checkOutput("held A after", {4'h0, ifa.out}, 8'h00);
        #(1191 - $time);
        checkOutput("held A quiet", {4'h0, ifa.out}, 8'h00);

        #(1240 - $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
